// File: rtl/hs32_mem_arbiter_if.sv
// Wishbone master bus shared by the two HS32 core memory ports.
interface hs32_mem_arbiter_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Two-core to one-Wishbone-master arbiter: one-deep request buffer per core,
// round-robin or fixed priority, one bus cycle at a time, bounded by a timeout.
module hs32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          FIXED_PRIO     = 1'b0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               c0_stb,
    input  logic               c0_rw,
    input  logic [31:0]        c0_addr,
    input  logic [31:0]        c0_dtw,
    output logic [31:0]        c0_dtr,
    output logic               c0_ack,
    output logic               c0_err,
    input  logic               c1_stb,
    input  logic               c1_rw,
    input  logic [31:0]        c1_addr,
    input  logic [31:0]        c1_dtw,
    output logic [31:0]        c1_dtr,
    output logic               c1_ack,
    output logic               c1_err,
    hs32_mem_arbiter_if.master wbm,
    output logic               busy_o,
    output logic               grant_o
);
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_pend;
    logic [1:0]       r_rw;
    logic [31:0]      r_addr [2];
    logic [31:0]      r_dtw  [2];
    logic [31:0]      r_dtr  [2];
    logic [1:0]       r_ack;
    logic [1:0]       r_err;
    logic             r_grant;
    logic             r_last_grant;
    logic [TMO_W-1:0] r_tmo;
    logic             w_winner;
    logic             w_start;
    logic             w_exit;
    logic             w_tmo_hit;
    logic             w_cyc;

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: pick a winner in IDLE, terminate the cycle in BUS
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_exit      = 1'b0;
        w_tmo_hit   = (r_tmo == TMO_LAST);
        if (r_pend == 2'b11) w_winner = FIXED_PRIO ? 1'b0 : ~r_last_grant;
        else                 w_winner = r_pend[1];
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm.wbm_ack_i || wbm.wbm_err_i || w_tmo_hit) begin
                    w_exit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs: the owner's buffer is held stable for the whole cycle
    always_comb begin
        w_cyc         = (r_state == S_BUS);
        wbm.wbm_cyc_o = w_cyc;
        wbm.wbm_stb_o = w_cyc;
        wbm.wbm_sel_o = w_cyc ? 4'hF : '0;
        wbm.wbm_we_o  = w_cyc & r_rw[r_grant];
        wbm.wbm_adr_o = w_cyc ? r_addr[r_grant] : '0;
        wbm.wbm_dat_o = w_cyc ? r_dtw[r_grant]  : '0;
        busy_o        = w_cyc;
        grant_o       = r_grant;
    end

    // Request capture, grant bookkeeping, timeout count and core responses
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pend       <= '0;
            r_rw         <= '0;
            r_addr[0]    <= '0;
            r_addr[1]    <= '0;
            r_dtw[0]     <= '0;
            r_dtw[1]     <= '0;
            r_dtr[0]     <= '0;
            r_dtr[1]     <= '0;
            r_ack        <= '0;
            r_err        <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_tmo        <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            // A strobe while the buffer is still occupied is dropped.
            if (c0_stb && !r_pend[0]) begin
                r_pend[0] <= 1'b1;
                r_rw[0]   <= c0_rw;
                r_addr[0] <= c0_addr;
                r_dtw[0]  <= c0_dtw;
            end
            if (c1_stb && !r_pend[1]) begin
                r_pend[1] <= 1'b1;
                r_rw[1]   <= c1_rw;
                r_addr[1] <= c1_addr;
                r_dtw[1]  <= c1_dtw;
            end
            if (w_start) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_tmo        <= '0;
            end else if (r_state == S_BUS) begin
                r_tmo <= r_tmo + 1'b1;
            end
            // Exiting without ack_i can only be slave error or timeout.
            if (w_exit) begin
                r_pend[r_grant] <= 1'b0;
                if (wbm.wbm_err_i || !wbm.wbm_ack_i) begin
                    r_err[r_grant] <= 1'b1;
                    r_dtr[r_grant] <= '0;
                end else begin
                    r_ack[r_grant] <= 1'b1;
                    if (!r_rw[r_grant]) r_dtr[r_grant] <= wbm.wbm_dat_i;
                end
            end
        end
    end

    assign c0_dtr = r_dtr[0];
    assign c1_dtr = r_dtr[1];
    assign c0_ack = r_ack[0];
    assign c1_ack = r_ack[1];
    assign c0_err = r_err[0];
    assign c1_err = r_err[1];
endmodule
